// File: rtl/llc_bus_snoop_responder_if.sv
// rtl/llc_bus_snoop_responder_if.sv - LLC request, snoop broadcast/response and completion signals
interface llc_bus_snoop_responder_if #(
    parameter int ADDR_BITS    = 32,
    parameter int NUM_SNOOPERS = 3
);
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [ADDR_BITS-1:0]      req_addr;
    logic                      snp_valid;
    logic [1:0]                snp_op;
    logic [ADDR_BITS-1:0]      snp_addr;
    logic [NUM_SNOOPERS-1:0]   snp_rsp_valid;
    logic [2*NUM_SNOOPERS-1:0] snp_rsp;
    logic                      wb_done;
    logic                      rsp_valid;
    logic [1:0]                rsp_result;
    logic                      rsp_timeout;
    logic [15:0]               hitm_count;

    // LLC plus peer caches: everything around the responder
    modport master (
        output req_valid, req_op, req_addr, snp_rsp_valid, snp_rsp, wb_done,
        input  req_ready, snp_valid, snp_op, snp_addr, rsp_valid, rsp_result, rsp_timeout, hitm_count
    );

    modport slave (
        input  req_valid, req_op, req_addr, snp_rsp_valid, snp_rsp, wb_done,
        output req_ready, snp_valid, snp_op, snp_addr, rsp_valid, rsp_result, rsp_timeout, hitm_count
    );
endinterface

// File: rtl/llc_bus_snoop_responder.sv
// rtl/llc_bus_snoop_responder.sv - bus-side snoop broadcast, response merge, writeback wait and memory latency
module llc_bus_snoop_responder #(
    parameter int ADDR_BITS     = 32,
    parameter int NUM_SNOOPERS  = 3,
    parameter int SNOOP_TIMEOUT = 15,
    parameter int MEM_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    llc_bus_snoop_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_COLLECT, S_WAIT_WB, S_MEM, S_DONE
    } state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_RWIM   = 2'b11;
    localparam logic [1:0] RES_HIT   = 2'b00;
    localparam logic [1:0] RES_HITM  = 2'b01;
    localparam logic [1:0] RES_NOHIT = 2'b10;

    localparam int TW = $clog2(SNOOP_TIMEOUT + 1);
    localparam int MW = $clog2(MEM_LATENCY + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(SNOOP_TIMEOUT - 1);
    localparam logic [MW-1:0] MEM_LAST = MW'(MEM_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [NUM_SNOOPERS-1:0] mask_q, mask_d;
    logic                    hit_q, hit_d;
    logic                    hitm_q, hitm_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [MW-1:0]           mem_cnt_q, mem_cnt_d;
    logic [1:0]              res_q, res_d;
    logic                    tmo_q, tmo_d;
    logic [1:0]              rsp_result_q, rsp_result_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [15:0]             hitm_count_q, hitm_count_d;

    logic [NUM_SNOOPERS-1:0] new_mask;
    logic                    new_hit, new_hitm;
    logic                    mask_all, collect_exit;
    logic [1:0]              merged;
    logic                    accept;

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    // First strobe from each snooper wins; repeats are masked off
    always_comb begin
        new_mask = '0;
        new_hit  = hit_q;
        new_hitm = hitm_q;
        if (state_q == S_COLLECT) begin
            new_mask = bus.snp_rsp_valid & ~mask_q;
            for (int i = 0; i < NUM_SNOOPERS; i++) begin
                if (new_mask[i]) begin
                    case (bus.snp_rsp[2*i +: 2])
                        RES_HIT:  new_hit  = 1'b1;
                        RES_HITM: new_hitm = 1'b1;
                        default:  ;
                    endcase
                end
            end
        end
        mask_all     = &(mask_q | new_mask);
        collect_exit = (state_q == S_COLLECT) && (mask_all || (timer_q == TMO_LAST));
        merged       = new_hitm ? RES_HITM : (new_hit ? RES_HIT : RES_NOHIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.req_valid) state_d = (bus.req_op == OP_WRITE) ? S_MEM : S_SNOOP;
            S_SNOOP:   state_d = S_COLLECT;
            S_COLLECT: begin
                if (collect_exit) begin
                    if (merged == RES_HITM && (op_q == OP_READ || op_q == OP_RWIM)) state_d = S_WAIT_WB;
                    else if (op_q == OP_INVAL)                                      state_d = S_DONE;
                    else                                                            state_d = S_MEM;
                end
            end
            S_WAIT_WB: if (bus.wb_done) state_d = S_MEM;
            S_MEM:     if (mem_cnt_q == MEM_LAST) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.snp_valid = (state_q == S_SNOOP);
        bus.rsp_valid = (state_q == S_DONE);
    end

    always_comb begin
        op_d          = op_q;
        addr_d        = addr_q;
        mask_d        = mask_q;
        hit_d         = hit_q;
        hitm_d        = hitm_q;
        timer_d       = timer_q;
        res_d         = res_q;
        tmo_d         = tmo_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        hitm_count_d  = hitm_count_q;
        mem_cnt_d     = (state_q == S_MEM) ? mem_cnt_q + 1'b1 : '0;

        // WRITE skips COLLECT, so the NOHIT/no-timeout defaults set here are what it reports
        if (accept) begin
            op_d    = bus.req_op;
            addr_d  = bus.req_addr;
            mask_d  = '0;
            hit_d   = 1'b0;
            hitm_d  = 1'b0;
            timer_d = '0;
            res_d   = RES_NOHIT;
            tmo_d   = 1'b0;
        end

        if (state_q == S_COLLECT) begin
            mask_d  = mask_q | new_mask;
            hit_d   = new_hit;
            hitm_d  = new_hitm;
            timer_d = timer_q + 1'b1;
            if (collect_exit) begin
                res_d = merged;
                tmo_d = ~mask_all;
            end
        end

        if (state_q == S_DONE) begin
            rsp_result_d  = res_q;
            rsp_timeout_d = tmo_q;
            if (res_q == RES_HITM && hitm_count_q != 16'hFFFF) hitm_count_d = hitm_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= '0;
            addr_q        <= '0;
            mask_q        <= '0;
            hit_q         <= 1'b0;
            hitm_q        <= 1'b0;
            timer_q       <= '0;
            mem_cnt_q     <= '0;
            res_q         <= RES_NOHIT;
            tmo_q         <= 1'b0;
            rsp_result_q  <= RES_NOHIT;
            rsp_timeout_q <= 1'b0;
            hitm_count_q  <= '0;
        end else begin
            op_q          <= op_d;
            addr_q        <= addr_d;
            mask_q        <= mask_d;
            hit_q         <= hit_d;
            hitm_q        <= hitm_d;
            timer_q       <= timer_d;
            mem_cnt_q     <= mem_cnt_d;
            res_q         <= res_d;
            tmo_q         <= tmo_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            hitm_count_q  <= hitm_count_d;
        end
    end

    // The new result shows during the DONE cycle itself and is held afterwards
    assign bus.rsp_result  = (state_q == S_DONE) ? res_q : rsp_result_q;
    assign bus.rsp_timeout = (state_q == S_DONE) ? tmo_q : rsp_timeout_q;
    assign bus.snp_op      = op_q;
    assign bus.snp_addr    = addr_q;
    assign bus.hitm_count  = hitm_count_q;
endmodule

// File: tb/tb_llc_bus_snoop_responder.sv
// tb/tb_llc_bus_snoop_responder.sv - directed bench for llc_bus_snoop_responder
module tb_llc_bus_snoop_responder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic seen;

    llc_bus_snoop_responder_if #(.ADDR_BITS(32), .NUM_SNOOPERS(3)) bus ();

    llc_bus_snoop_responder #(
        .ADDR_BITS(32), .NUM_SNOOPERS(3), .SNOOP_TIMEOUT(15), .MEM_LATENCY(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_snoop;
        bus.snp_rsp_valid = 3'b000;
        bus.snp_rsp       = 6'b10_10_10;
        bus.wb_done       = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;
        clear_snoop();
        tick();
        tick();

        // reset values
        chk("rst_req_ready",   32'(bus.req_ready),   32'd1);
        chk("rst_snp_valid",   32'(bus.snp_valid),   32'd0);
        chk("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
        chk("rst_rsp_result",  32'(bus.rsp_result),  32'd2);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("rst_snp_op",      32'(bus.snp_op),      32'd0);
        chk("rst_snp_addr",    bus.snp_addr,         32'd0);
        chk("rst_hitm_count",  32'(bus.hitm_count),  32'd0);
        rst_n = 1'b1;
        tick();

        // reset in the middle of a READ's MEM phase
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_addr = 32'h0000_0500;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.snp_rsp_valid = 3'b111; bus.snp_rsp = 6'b10_10_10;
        tick();
        clear_snoop();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_snp_addr",  bus.snp_addr,       32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | bus.rsp_valid;
        end
        chk("midrst_no_rsp",    32'(seen),          32'd0);
        chk("midrst_ready_after", 32'(bus.req_ready), 32'd1);

        // READ 0x1000, NOHIT/HIT/NOHIT
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_addr = 32'h0000_1000;
        tick();
        bus.req_valid = 1'b0;
        chk("rd_snp_valid_t1", 32'(bus.snp_valid), 32'd1);
        chk("rd_req_ready_t1", 32'(bus.req_ready), 32'd0);
        chk("rd_snp_addr",     bus.snp_addr,       32'h0000_1000);
        chk("rd_snp_op",       32'(bus.snp_op),    32'd0);
        tick();
        chk("rd_snp_valid_t2", 32'(bus.snp_valid), 32'd0);
        bus.snp_rsp_valid = 3'b111; bus.snp_rsp = 6'b10_00_10;
        tick();
        clear_snoop();
        repeat (3) tick();
        chk("rd_rsp_valid_t6", 32'(bus.rsp_valid),   32'd0);
        tick();
        chk("rd_rsp_valid_t7", 32'(bus.rsp_valid),   32'd1);
        chk("rd_result",       32'(bus.rsp_result),  32'd0);
        chk("rd_timeout",      32'(bus.rsp_timeout), 32'd0);
        tick();
        chk("rd_rsp_valid_t8", 32'(bus.rsp_valid),   32'd0);
        chk("rd_result_held",  32'(bus.rsp_result),  32'd0);
        chk("rd_ready_t8",     32'(bus.req_ready),   32'd1);

        // RWIM, snooper1 HITM, early wb_done ignored, real wb_done at T+7
        bus.req_valid = 1'b1; bus.req_op = 2'b11; bus.req_addr = 32'h0000_1040;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.snp_rsp_valid = 3'b111; bus.snp_rsp = 6'b10_01_10; bus.wb_done = 1'b1;
        tick();
        clear_snoop();
        chk("rwim_busy_t3", 32'(bus.req_ready), 32'd0);
        repeat (3) tick();
        chk("rwim_rsp_valid_t6", 32'(bus.rsp_valid), 32'd0);
        tick();
        bus.wb_done = 1'b1;
        tick();
        bus.wb_done = 1'b0;
        repeat (3) tick();
        chk("rwim_rsp_valid_t11", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("rwim_rsp_valid_t12", 32'(bus.rsp_valid),  32'd1);
        chk("rwim_result",        32'(bus.rsp_result), 32'd1);
        chk("rwim_hitm_before",   32'(bus.hitm_count), 32'd0);
        tick();
        chk("rwim_hitm_after",    32'(bus.hitm_count), 32'd1);

        // INVALIDATE with snooper1 silent -> timeout after 15 COLLECT cycles
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_addr = 32'h0000_1080;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.snp_rsp_valid = 3'b101; bus.snp_rsp = 6'b00_10_00;
        tick();
        clear_snoop();
        repeat (13) tick();
        chk("inv_rsp_valid_t16", 32'(bus.rsp_valid),   32'd0);
        tick();
        chk("inv_rsp_valid_t17", 32'(bus.rsp_valid),   32'd1);
        chk("inv_result",        32'(bus.rsp_result),  32'd0);
        chk("inv_timeout",       32'(bus.rsp_timeout), 32'd1);
        chk("inv_hitm_count",    32'(bus.hitm_count),  32'd1);
        tick();

        // WRITE 0x2040 with req_valid held; a stray snoop strobe is ignored
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_addr = 32'h0000_2040;
        tick();
        chk("wr_snp_valid_t1", 32'(bus.snp_valid), 32'd0);
        chk("wr_req_ready_t1", 32'(bus.req_ready), 32'd0);
        chk("wr_snp_addr",     bus.snp_addr,       32'h0000_2040);
        tick();
        bus.snp_rsp_valid = 3'b001; bus.snp_rsp = 6'b10_10_01;
        tick();
        clear_snoop();
        tick();
        chk("wr_rsp_valid_t4", 32'(bus.rsp_valid),   32'd0);
        chk("wr_req_ready_t4", 32'(bus.req_ready),   32'd0);
        chk("wr_snp_addr_held", bus.snp_addr,        32'h0000_2040);
        tick();
        chk("wr_rsp_valid_t5", 32'(bus.rsp_valid),   32'd1);
        chk("wr_result",       32'(bus.rsp_result),  32'd2);
        chk("wr_timeout",      32'(bus.rsp_timeout), 32'd0);
        chk("wr_req_ready_t5", 32'(bus.req_ready),   32'd0);
        bus.req_op = 2'b00; bus.req_addr = 32'h0000_3000;
        tick();
        chk("rd2_ready_t6",   32'(bus.req_ready), 32'd1);
        chk("rd2_no_snoop_t6", 32'(bus.snp_valid), 32'd0);

        // READ 0x3000: snooper0 strobes HITM then NOHIT; first response wins
        tick();
        bus.req_valid = 1'b0;
        chk("rd2_snp_valid", 32'(bus.snp_valid), 32'd1);
        chk("rd2_snp_addr",  bus.snp_addr,       32'h0000_3000);
        tick();
        bus.snp_rsp_valid = 3'b001; bus.snp_rsp = 6'b10_10_01;
        tick();
        bus.snp_rsp_valid = 3'b111; bus.snp_rsp = 6'b10_10_10;
        tick();
        clear_snoop();
        bus.wb_done = 1'b1;
        tick();
        bus.wb_done = 1'b0;
        repeat (3) tick();
        chk("rd2_rsp_valid_t8", 32'(bus.rsp_valid),   32'd0);
        tick();
        chk("rd2_rsp_valid_t9", 32'(bus.rsp_valid),   32'd1);
        chk("rd2_result",       32'(bus.rsp_result),  32'd1);
        chk("rd2_timeout",      32'(bus.rsp_timeout), 32'd0);
        tick();
        chk("rd2_hitm_count",   32'(bus.hitm_count),  32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
